cv32e40px_regfile_scb: RTL and testbench
========================================

CV32E40PX_REGFILE_SCB -- requirements
Module: cv32e40px_regfile_scb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, register address width; bit ADDR_WIDTH-1 selects the FP bank.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 SHALL have parameter NUM_RPORTS, default 3, range 1..4, number of read ports.
REQ-004 SHALL have parameter NUM_WPORTS, default 2, range 1..3, number of write ports.
REQ-005 SHALL have parameter FPU, default 0, which enables the FP bank when 1 and ZFINX=0.
REQ-006 SHALL have parameter ZFINX, default 0; when 1, FP operands use the integer bank.
REQ-007 SHALL have parameter BYPASS, default 0; when 1, same-cycle write data is forwarded to the read ports.
REQ-008 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-009 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-010 SHALL have port raddr_i, input, NUM_RPORTS x ADDR_WIDTH, read addresses.
REQ-011 SHALL have port rdata_o, output, NUM_RPORTS x DATA_WIDTH, read data.
REQ-012 SHALL have port rbusy_o, output, NUM_RPORTS bits, pending bit of each read address.
REQ-013 SHALL have port waddr_i, input, NUM_WPORTS x ADDR_WIDTH, write addresses.
REQ-014 SHALL have port wdata_i, input, NUM_WPORTS x DATA_WIDTH, write data.
REQ-015 SHALL have port we_i, input, NUM_WPORTS bits, write enables.
REQ-016 SHALL have port wclr_i, input, NUM_WPORTS bits; a write with this bit set also clears the pending bit of its target.
REQ-017 SHALL have port rsv_valid_i, input, 1 bit, reservation request.
REQ-018 SHALL have port rsv_addr_i, input, ADDR_WIDTH bits, address to reserve.
REQ-019 SHALL have port rsv_ready_o, output, 1 bit, reservation accepted this cycle.
REQ-020 SHALL have port flush_i, input, 1 bit, which clears all pending bits.
REQ-021 SHALL have port npend_o, output, $clog2(NUM_TOT_WORDS+1) bits, count of pending registers.

Function
REQ-022 SHALL set NUM_WORDS = 2**(ADDR_WIDTH-1) and NUM_TOT_WORDS = 2*NUM_WORDS only when FPU=1 and ZFINX=0; otherwise NUM_TOT_WORDS = NUM_WORDS.
REQ-023 SHALL make integer register 0 read 0 always, never write, and never be pending.
REQ-024 SHALL, when the FP bank is absent, return 0 for FP-bank reads and ignore FP-bank writes and reservations (rsv_ready_o=1).
REQ-025 SHALL perform each write at the rising edge when we_i[k]=1; if several ports target one address, the highest-index port wins.
REQ-026 SHALL, with BYPASS=0, provide combinational read data from stored state only, so a written value is visible the cycle after the write.
REQ-027 SHALL, with BYPASS=1, return the winning same-cycle wdata_i when raddr_i matches an enabled write address (excluding x0).
REQ-028 SHALL keep one pending bit per register; rbusy_o[j] = pending[raddr_i[j]], combinational.
REQ-029 SHALL drive rsv_ready_o = rsv_valid_i AND NOT pending[rsv_addr_i]; a handshake sets the bit at the next edge. No double reservation (WAW guard).
REQ-030 SHALL clear the pending bit at the edge of a write with we_i[k]=1 and wclr_i[k]=1; a write with wclr_i=0 leaves the pending bit unchanged.
REQ-031 SHALL, on an accepted reservation and a clearing write to the same address in one cycle, let the set win, leaving the bit pending.
REQ-032 SHALL, on flush_i=1, clear all pending bits at the edge, override reservations in that cycle, and leave register data intact.
REQ-033 SHALL register npend_o, equal to the popcount of the pending bits after the same edge; it saturates by construction at NUM_TOT_WORDS.
REQ-034 SHALL accept a clearing write to a non-pending register as a normal write, with no count underflow.

Reset
REQ-035 SHALL, on rst_n=0, asynchronously clear all registers to 0, all pending bits to 0, and npend_o to 0; rsv_ready_o then follows REQ-029.
REQ-036 SHALL, on reset during an outstanding reservation, drop the reservation; later writebacks are plain writes.

Verification
REQ-037 SHALL verify: write x5=0xDEADBEEF via port0; next cycle read port1 addr 5 -> 0xDEADBEEF. Write x0=0x1 -> read 0.
REQ-038 SHALL verify: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> x7=0x22. With BYPASS=1 the same-cycle read gives 0x22.
REQ-039 SHALL verify: reserve x9 -> rsv_ready_o=1, next cycle rbusy=1 and npend_o=1; reserve x9 again -> rsv_ready_o=0; write x9 with wclr=1 -> rbusy=0, npend_o=0.
REQ-040 SHALL verify: with FPU=1, write addr 0x21=0x3F800000 -> reads 0x3F800000 while integer x1 is unchanged; with FPU=0, addr 0x21 reads 0.
REQ-041 SHALL verify: reserve x3, x4, x5, then flush_i -> npend_o goes 3->0 and data is kept; a reset mid-reservation gives all pending bits 0 and all registers 0.
REQ-042 SHALL verify: non-pending x6 gets a reservation and a clearing write in the same cycle -> x6 holds wdata and pending=1, npend_o=1.

Source files
------------

// File: rtl/cv32e40px_regfile_scb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cv32e40px_regfile_scb - multi-port register file with per-register pending-bit scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module cv32e40px_regfile_scb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int BYPASS     = 0,
    localparam int NUM_WORDS     = 2 ** (ADDR_WIDTH - 1),
    localparam int NUM_TOT_WORDS = ((FPU == 1) && (ZFINX == 0)) ? 2 * NUM_WORDS : NUM_WORDS,
    localparam int NPEND_W       = $clog2(NUM_TOT_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr_i     [NUM_RPORTS],
    output logic [DATA_WIDTH-1:0] rdata_o     [NUM_RPORTS],
    output logic [NUM_RPORTS-1:0] rbusy_o,
    input  logic [ADDR_WIDTH-1:0] waddr_i     [NUM_WPORTS],
    input  logic [DATA_WIDTH-1:0] wdata_i     [NUM_WPORTS],
    input  logic [NUM_WPORTS-1:0] we_i,
    input  logic [NUM_WPORTS-1:0] wclr_i,
    input  logic                  rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
    output logic                  rsv_ready_o,
    input  logic                  flush_i,
    output logic [NPEND_W-1:0]    npend_o
);

    localparam bit FP_EN = (FPU == 1) && (ZFINX == 0);
    // Without the FP bank the MSB only qualifies the address and never indexes storage.
    localparam int IDX_W = FP_EN ? ADDR_WIDTH : ADDR_WIDTH - 1;

    logic [DATA_WIDTH-1:0]    mem [NUM_TOT_WORDS];
    logic [NUM_TOT_WORDS-1:0] pend;
    logic [NUM_TOT_WORDS-1:0] pend_nxt;
    logic [NPEND_W-1:0]       npend_nxt;
    logic                     rsv_busy;

    // x0 and (when absent) the FP bank are never stored, read as 0 and never pending.
    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return (FP_EN || !a[ADDR_WIDTH-1]) && (a != '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TOT_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WPORTS; k++) begin
                if (we_i[k] && writable(waddr_i[k])) begin
                    mem[waddr_i[k][IDX_W-1:0]] <= wdata_i[k];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_RPORTS; j++) begin
            rdata_o[j] = writable(raddr_i[j]) ? mem[raddr_i[j][IDX_W-1:0]] : '0;
            rbusy_o[j] = writable(raddr_i[j]) && pend[raddr_i[j][IDX_W-1:0]];
            if (BYPASS == 1) begin
                for (int k = 0; k < NUM_WPORTS; k++) begin
                    if (we_i[k] && writable(waddr_i[k]) && (waddr_i[k] == raddr_i[j])) begin
                        rdata_o[j] = wdata_i[k];
                    end
                end
            end
        end
    end

    assign rsv_busy    = writable(rsv_addr_i) && pend[rsv_addr_i[IDX_W-1:0]];
    assign rsv_ready_o = rsv_valid_i && !rsv_busy;

    // Ordering gives the priorities: clear < reservation set < flush.
    always_comb begin
        pend_nxt = pend;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            if (we_i[k] && wclr_i[k] && writable(waddr_i[k])) begin
                pend_nxt[waddr_i[k][IDX_W-1:0]] = 1'b0;
            end
        end
        if (rsv_ready_o && writable(rsv_addr_i)) begin
            pend_nxt[rsv_addr_i[IDX_W-1:0]] = 1'b1;
        end
        if (flush_i) begin
            pend_nxt = '0;
        end
    end

    always_comb begin
        npend_nxt = '0;
        for (int i = 0; i < NUM_TOT_WORDS; i++) begin
            npend_nxt = npend_nxt + NPEND_W'(pend_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            npend_o <= '0;
        end else begin
            pend    <= pend_nxt;
            npend_o <= npend_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_regfile_scb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cv32e40px_regfile_scb - directed and random checks of two register file configurations
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cv32e40px_regfile_scb;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] raddr [NR];
    logic [AW-1:0] waddr [NW];
    logic [DW-1:0] wdata [NW];
    logic [NW-1:0] we;
    logic [NW-1:0] wclr;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic          flush;

    logic [DW-1:0] rdata_a [NR];
    logic [DW-1:0] rdata_b [NR];
    logic [NR-1:0] rbusy_a, rbusy_b;
    logic          rdy_a, rdy_b;
    logic [5:0]    npend_a;
    logic [6:0]    npend_b;

    // Configuration 0: integer bank only, no bypass. Configuration 1: FP bank plus bypass.
    cv32e40px_regfile_scb dut_a (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wclr_i(wclr), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(rdy_a), .flush_i(flush), .npend_o(npend_a)
    );

    cv32e40px_regfile_scb #(.FPU(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wclr_i(wclr), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(rdy_b), .flush_i(flush), .npend_o(npend_b)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] m_mem  [2][64];
    bit            m_pend [2][64];
    int            n_asserts = 0;
    int            n_fail    = 0;

    function automatic bit m_wr(input int c, input logic [AW-1:0] a);
        return (a != 0) && ((c == 1) || (a < 32));
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input int c, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = m_wr(c, a) ? m_mem[c][a] : '0;
        if (c == 1) begin
            for (int k = 0; k < NW; k++) begin
                if (we[k] && m_wr(c, waddr[k]) && (waddr[k] == a)) v = wdata[k];
            end
        end
        return v;
    endfunction

    function automatic bit exp_busy(input int c, input logic [AW-1:0] a);
        return m_wr(c, a) && m_pend[c][a];
    endfunction

    function automatic bit exp_ready(input int c);
        return rsv_valid && !exp_busy(c, rsv_addr);
    endfunction

    function automatic int m_count(input int c);
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(m_pend[c][i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 64; i++) begin
                m_mem[c][i]  = '0;
                m_pend[c][i] = 1'b0;
            end
        end
    endtask

    task automatic m_tick();
        for (int c = 0; c < 2; c++) begin
            bit rdy;
            rdy = exp_ready(c);
            for (int k = 0; k < NW; k++) begin
                if (we[k] && m_wr(c, waddr[k])) m_mem[c][waddr[k]] = wdata[k];
            end
            for (int k = 0; k < NW; k++) begin
                if (we[k] && wclr[k] && m_wr(c, waddr[k])) m_pend[c][waddr[k]] = 1'b0;
            end
            if (rdy && m_wr(c, rsv_addr)) m_pend[c][rsv_addr] = 1'b1;
            if (flush) begin
                for (int i = 0; i < 64; i++) m_pend[c][i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic settle();
        #1;
        for (int j = 0; j < NR; j++) begin
            chk($sformatf("rdata_a[%0d]", j), 64'(rdata_a[j]), 64'(exp_rdata(0, raddr[j])));
            chk($sformatf("rdata_b[%0d]", j), 64'(rdata_b[j]), 64'(exp_rdata(1, raddr[j])));
            chk($sformatf("rbusy_a[%0d]", j), 64'(rbusy_a[j]), 64'(exp_busy(0, raddr[j])));
            chk($sformatf("rbusy_b[%0d]", j), 64'(rbusy_b[j]), 64'(exp_busy(1, raddr[j])));
        end
        chk("rsv_ready_a", 64'(rdy_a), 64'(exp_ready(0)));
        chk("rsv_ready_b", 64'(rdy_b), 64'(exp_ready(1)));
    endtask

    task automatic tick();
        @(posedge clk);
        m_tick();
        #1;
        chk("npend_a", 64'(npend_a), 64'(m_count(0)));
        chk("npend_b", 64'(npend_b), 64'(m_count(1)));
    endtask

    task automatic idle();
        we        = '0;
        wclr      = '0;
        rsv_valid = 1'b0;
        flush     = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom_range(0, 7));
            1:       return AW'(32 + $urandom_range(0, 7));
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic rand_cycle();
        for (int j = 0; j < NR; j++) raddr[j] = rand_addr();
        for (int k = 0; k < NW; k++) begin
            waddr[k] = rand_addr();
            wdata[k] = $urandom;
        end
        we        = NW'($urandom);
        wclr      = NW'($urandom);
        rsv_valid = 1'($urandom);
        rsv_addr  = rand_addr();
        flush     = ($urandom_range(0, 15) == 0);
        settle();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rsv_addr = '0;
        for (int j = 0; j < NR; j++) raddr[j] = '0;
        for (int k = 0; k < NW; k++) begin
            waddr[k] = '0;
            wdata[k] = '0;
        end
        m_reset();
        @(posedge clk);
        #1;
        settle();
        chk("reset_npend_a", 64'(npend_a), 64'd0);
        chk("reset_npend_b", 64'(npend_b), 64'd0);
        rst_n = 1'b1;
        tick();

        // Write x5, read it back next cycle; x0 ignores writes.
        we[0] = 1'b1; waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF; raddr[1] = 6'd5;
        settle();
        chk("bypass_x5_b", 64'(rdata_b[1]), 64'hDEADBEEF);
        tick();
        idle();
        settle();
        chk("x5_a", 64'(rdata_a[1]), 64'hDEADBEEF);
        chk("x5_b", 64'(rdata_b[1]), 64'hDEADBEEF);
        we[0] = 1'b1; waddr[0] = 6'd0; wdata[0] = 32'h1; raddr[0] = 6'd0;
        settle();
        tick();
        idle();
        settle();
        chk("x0_a", 64'(rdata_a[0]), 64'd0);
        chk("x0_b", 64'(rdata_b[0]), 64'd0);

        // Two ports write x7 together: the higher port wins.
        we = 2'b11; waddr[0] = 6'd7; wdata[0] = 32'h11; waddr[1] = 6'd7; wdata[1] = 32'h22;
        raddr[0] = 6'd7;
        settle();
        chk("same_cycle_x7_b", 64'(rdata_b[0]), 64'h22);
        chk("same_cycle_x7_a", 64'(rdata_a[0]), 64'd0);
        tick();
        idle();
        settle();
        chk("x7_a", 64'(rdata_a[0]), 64'h22);
        chk("x7_b", 64'(rdata_b[0]), 64'h22);

        // Reserve x9, double reservation refused, clearing write releases it.
        rsv_valid = 1'b1; rsv_addr = 6'd9; raddr[0] = 6'd9;
        settle();
        chk("rsv9_ready_a", 64'(rdy_a), 64'd1);
        tick();
        chk("rsv9_npend_a", 64'(npend_a), 64'd1);
        chk("rsv9_npend_b", 64'(npend_b), 64'd1);
        settle();
        chk("rsv9_busy_a", 64'(rbusy_a[0]), 64'd1);
        chk("rsv9_again_ready_b", 64'(rdy_b), 64'd0);
        tick();
        idle();
        we[0] = 1'b1; wclr[0] = 1'b1; waddr[0] = 6'd9; wdata[0] = 32'h99;
        settle();
        tick();
        idle();
        settle();
        chk("x9_clr_busy_a", 64'(rbusy_a[0]), 64'd0);
        chk("x9_clr_npend_b", 64'(npend_b), 64'd0);

        // FP bank write at 0x21 leaves x1 alone; absent FP bank reads 0.
        we[0] = 1'b1; waddr[0] = 6'h21; wdata[0] = 32'h3F800000;
        settle();
        tick();
        idle();
        raddr[0] = 6'h21; raddr[1] = 6'd1;
        settle();
        chk("fp21_b", 64'(rdata_b[0]), 64'h3F800000);
        chk("fp21_a", 64'(rdata_a[0]), 64'd0);
        chk("x1_b", 64'(rdata_b[1]), 64'd0);

        // Three reservations then flush; data kept.
        for (int r = 3; r <= 5; r++) begin
            rsv_valid = 1'b1; rsv_addr = AW'(r);
            settle();
            tick();
        end
        chk("three_rsv_npend_a", 64'(npend_a), 64'd3);
        idle();
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 6'd8;
        settle();
        tick();
        idle();
        raddr[0] = 6'd5;
        chk("flush_npend_b", 64'(npend_b), 64'd0);
        settle();
        chk("flush_keep_x5_a", 64'(rdata_a[0]), 64'hDEADBEEF);

        // Reservation and clearing write to free x6 in one cycle: set wins.
        rsv_valid = 1'b1; rsv_addr = 6'd6;
        we[0] = 1'b1; wclr[0] = 1'b1; waddr[0] = 6'd6; wdata[0] = 32'h66;
        settle();
        tick();
        idle();
        raddr[0] = 6'd6;
        settle();
        chk("x6_data_a", 64'(rdata_a[0]), 64'h66);
        chk("x6_busy_b", 64'(rbusy_b[0]), 64'd1);
        chk("x6_npend_a", 64'(npend_a), 64'd1);

        // Reset in the middle of an outstanding reservation.
        rsv_valid = 1'b1; rsv_addr = 6'd10;
        settle();
        tick();
        idle();
        raddr[0] = 6'd5; raddr[1] = 6'd10; raddr[2] = 6'd6;
        rst_n = 1'b0;
        m_reset();
        settle();
        chk("rst_npend_a", 64'(npend_a), 64'd0);
        chk("rst_npend_b", 64'(npend_b), 64'd0);
        chk("rst_x5_b", 64'(rdata_b[0]), 64'd0);
        rst_n = 1'b1;
        we[0] = 1'b1; wclr[0] = 1'b1; waddr[0] = 6'd10; wdata[0] = 32'hA5A5;
        settle();
        tick();
        idle();
        settle();
        chk("post_rst_x10_a", 64'(rdata_a[1]), 64'hA5A5);
        chk("post_rst_npend_a", 64'(npend_a), 64'd0);

        for (int n = 0; n < 400; n++) rand_cycle();
        idle();
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
